mmu_port_arbiter: RTL and testbench
===================================

// Module: mmu_port_arbiter
// PURPOSE
// - Shares the single MMU request port between two requesters: M0 = instruction fetch, M1 = load/store.
// - Sits between cpu and mmu in soc. Latches the winning request, drives the MMU until mem_ready,
//   returns registered read data plus a one-cycle ready pulse to the winner.
// - Optional timeout aborts a hung MMU access and flags an error.
// PARAMETERS
// - RR_ENABLE       1   1 = round-robin on simultaneous requests; 0 = fixed priority, M0 wins
// - TIMEOUT_CYCLES  0   max cycles in ISSUE before abort; 0 = timeout disabled (16-bit counter)
// PORTS
// - clk                  in   1   system clock; all state on rising edge
// - reset                in   1   asynchronous, active-high reset
// - mN_read_enable       in   1   master N read request (N = 0,1; all mN_* ports duplicated per master)
// - mN_write_enable      in   1   master N write request
// - mN_mem_signed_read   in   1   sign-extend sub-word read
// - mN_mem_data_width    in   2   00 byte, 01 half, 10 word
// - mN_address           in   32  byte address
// - mN_data_in           in   32  write data
// - mN_data_out          out  32  read data, valid while mN_mem_ready = 1
// - mN_mem_ready         out  1   one-cycle completion pulse
// - mN_error             out  1   one-cycle pulse with mN_mem_ready when access timed out
// - mmu_read_enable      out  1   to mmu read_enable
// - mmu_write_enable     out  1   to mmu write_enable
// - mmu_mem_signed_read  out  1   to mmu mem_signed_read
// - mmu_mem_data_width   out  2   to mmu mem_data_width
// - mmu_address          out  32  to mmu address
// - mmu_data_in          out  32  to mmu data_in
// - mmu_data_out         in   32  from mmu data_out
// - mmu_mem_ready        in   1   from mmu mem_ready
// - timeout_sticky       out  1   set on any timeout, cleared only by reset
// BEHAVIOUR
// - Reset: state IDLE, every output 0, last_grant = M1 (so M0 wins first tie), timeout counter 0.
//   Reset mid-transaction drops mmu_*_enable asynchronously; the pending access is lost, no ready issued.
// - Request from master N = mN_read_enable | mN_write_enable. Both high -> write; read forwarded as 0.
// - FSM (registered): IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE: ignore mmu_mem_ready. If any request, pick winner, latch its 6 request fields into the
//         request register, update last_grant, go ISSUE. No request -> stay.
//   ISSUE: mmu_* driven from request register only (never from live master inputs); enables held
//         high every cycle. On mmu_mem_ready = 1: capture mmu_data_out, go RESP.
//         Timeout (TIMEOUT_CYCLES != 0): counter cleared on IDLE->ISSUE, +1 per ISSUE cycle without
//         mmu_mem_ready; reaching TIMEOUT_CYCLES -> go RESP with data 0, error, timeout_sticky <= 1.
//         mmu_mem_ready in the same cycle the count is reached wins (normal completion).
//   RESP: exactly one cycle; winner's mN_mem_ready = 1, mN_data_out = captured data, mN_error as set;
//         mmu enables 0. Loser outputs stay 0. Always -> IDLE.
// - Latency: request in IDLE at cycle t -> mmu enables high t+1; mmu_mem_ready at cycle t+k (k >= 1)
//   -> mN_mem_ready at t+k+1. Minimum turnaround 3 cycles per access; one IDLE bubble between grants.
// - Requester contract: hold request stable until mN_mem_ready seen; may change it the cycle after.
//   Arbiter never samples requests in RESP, so a held request is not re-granted.
// - Arbitration: single request -> granted. Both, RR_ENABLE=1 -> master != last_grant; RR_ENABLE=0 -> M0.
// - Master dropping its request while granted: ignored; transaction completes, ready still pulses.
// - mN_data_out is 0 whenever mN_mem_ready = 0. Writes return captured mmu_data_out unchanged.
// STRUCTURE
// - mmu_pkg.vh: state encodings (IDLE/ISSUE/RESP), master IDs, data-width codes, TIMEOUT counter width.
// - Sub-module arb2_pick: combinational 2-way picker (req[1:0], last_grant, RR_ENABLE) -> grant id.
// - Top: FSM, request register, response register, timeout counter; soc instantiates between cpu/mmu.
// TESTING
// - Single M0 word read @0x100, mmu ready 2 cycles after issue, data 0xDEADBEEF -> m0_mem_ready one
//   cycle at t+3, m0_data_out = 0xDEADBEEF, m1 outputs 0, mmu_address = 0x100 held through ISSUE.
// - Both request every cycle, RR_ENABLE=1 -> grants M0,M1,M0,M1; RR_ENABLE=0 -> M0 only, M1 starved.
// - M1 byte write 0x55 @0x204, M1 changes address mid-ISSUE -> mmu_address stays 0x204, width 00.
// - M0 asserts read+write together -> mmu_write_enable=1, mmu_read_enable=0.
// - TIMEOUT_CYCLES=4, mmu never ready -> after 4 ISSUE cycles m0_mem_ready=1, m0_error=1, data 0,
//   timeout_sticky=1 until reset; ready on 4th cycle instead -> normal completion, no error.
// - Assert reset during ISSUE -> mmu enables 0 immediately, no mN_mem_ready; after release M0 wins tie.

Source files
------------

// File: rtl/mmu_port_arbiter_pkg.sv
// Shared types for the two-master MMU port arbiter: FSM states, master ids,
// access width codes and the latched request record.
package mmu_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_WORD = 2'b10
  } data_width_e;

  localparam int TIMEOUT_W = 16;

  typedef struct packed {
    logic        read_enable;
    logic        write_enable;
    logic        signed_read;
    data_width_e data_width;
    logic [31:0] address;
    logic [31:0] data_in;
  } mem_req_t;

  // A request with both enables set is a write; the read is dropped.
  function automatic mem_req_t make_req(input logic rd, input logic wr, input logic sgn,
                                        input logic [1:0] width, input logic [31:0] addr,
                                        input logic [31:0] din);
    mem_req_t r;
    r.read_enable  = rd & ~wr;
    r.write_enable = wr;
    r.signed_read  = sgn;
    r.data_width   = data_width_e'(width);
    r.address      = addr;
    r.data_in      = din;
    return r;
  endfunction

endpackage

// File: rtl/mmu_port_arbiter_if.sv
// Memory request port: requester drives the request fields, responder returns data,
// a one-cycle ready pulse and (towards the CPU masters) an error flag.
interface mmu_port_arbiter_if;
  logic        read_enable;
  logic        write_enable;
  logic        mem_signed_read;
  logic [1:0]  mem_data_width;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mem_ready;
  logic        error;

  modport master (
    output read_enable, write_enable, mem_signed_read, mem_data_width, address, data_in,
    input  data_out, mem_ready, error
  );

  modport slave (
    input  read_enable, write_enable, mem_signed_read, mem_data_width, address, data_in,
    output data_out, mem_ready, error
  );

  // The MMU itself has no error output, so the arbiter's downstream port omits it.
  modport mmu_master (
    output read_enable, write_enable, mem_signed_read, mem_data_width, address, data_in,
    input  data_out, mem_ready
  );
endinterface

// File: rtl/mmu_port_arbiter_arb2_pick.sv
// Combinational two-way picker: a lone requester wins; on a tie either round-robin
// against the previous grant or fixed priority to master 0.
module mmu_port_arbiter_arb2_pick
  import mmu_port_arbiter_pkg::*;
#(
  parameter int RR_ENABLE = 1
) (
  input  logic [1:0] req_i,
  input  master_e    last_grant_i,
  output master_e    grant_o
);

  always_comb begin
    grant_o = MASTER_0;
    case (req_i)
      2'b10:   grant_o = MASTER_1;
      2'b11:   if ((RR_ENABLE != 0) && (last_grant_i == MASTER_0)) grant_o = MASTER_1;
      default: grant_o = MASTER_0;
    endcase
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// Shares one MMU port between instruction fetch (m0) and load/store (m1): latch the
// winner's request, hold it on the MMU until ready or timeout, then pulse ready back.
module mmu_port_arbiter
  import mmu_port_arbiter_pkg::*;
#(
  parameter int RR_ENABLE      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  mmu_port_arbiter_if.slave        m0,
  mmu_port_arbiter_if.slave        m1,
  mmu_port_arbiter_if.mmu_master   mmu,
  output logic                     timeout_sticky
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  master_e                last_grant_q, last_grant_d, grantId;
  mem_req_t               req_q, req_d, req0, req1;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   sticky_q, sticky_d;
  logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [1:0]             reqVec;
  logic                   tmoHit;

  assign req0   = make_req(m0.read_enable, m0.write_enable, m0.mem_signed_read,
                           m0.mem_data_width, m0.address, m0.data_in);
  assign req1   = make_req(m1.read_enable, m1.write_enable, m1.mem_signed_read,
                           m1.mem_data_width, m1.address, m1.data_in);
  assign reqVec = {m1.read_enable | m1.write_enable, m0.read_enable | m0.write_enable};
  assign tmoHit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TIMEOUT_LIMIT - TIMEOUT_W'(1));
  assign timeout_sticky = sticky_q;

  mmu_port_arbiter_arb2_pick #(.RR_ENABLE(RR_ENABLE)) u_pick (
    .req_i        (reqVec),
    .last_grant_i (last_grant_q),
    .grant_o      (grantId)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|reqVec) state_d = ST_ISSUE;
      ST_ISSUE: if (mmu.mem_ready || tmoHit) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A ready arriving on the same cycle the timeout limit is reached completes normally.
  always_comb begin
    req_d        = req_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    sticky_d     = sticky_q;
    tmo_cnt_d    = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|reqVec) begin
          req_d        = (grantId == MASTER_1) ? req1 : req0;
          last_grant_d = grantId;
          rdata_d      = '0;
          err_d        = 1'b0;
          tmo_cnt_d    = '0;
        end
      end
      ST_ISSUE: begin
        if (mmu.mem_ready) begin
          rdata_d = mmu.data_out;
        end else if (tmoHit) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          sticky_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= '0;
      last_grant_q <= MASTER_1;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      sticky_q     <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      sticky_q     <= sticky_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Outputs decode from the registered state, so an async reset clears them at once.
  always_comb begin
    mmu.read_enable     = 1'b0;
    mmu.write_enable    = 1'b0;
    mmu.mem_signed_read = 1'b0;
    mmu.mem_data_width  = 2'b00;
    mmu.address         = '0;
    mmu.data_in         = '0;
    m0.mem_ready        = 1'b0;
    m0.data_out         = '0;
    m0.error            = 1'b0;
    m1.mem_ready        = 1'b0;
    m1.data_out         = '0;
    m1.error            = 1'b0;
    if (state_q == ST_ISSUE) begin
      mmu.read_enable     = req_q.read_enable;
      mmu.write_enable    = req_q.write_enable;
      mmu.mem_signed_read = req_q.signed_read;
      mmu.mem_data_width  = req_q.data_width;
      mmu.address         = req_q.address;
      mmu.data_in         = req_q.data_in;
    end
    if (state_q == ST_RESP) begin
      if (last_grant_q == MASTER_0) begin
        m0.mem_ready = 1'b1;
        m0.data_out  = rdata_q;
        m0.error     = err_q;
      end else begin
        m1.mem_ready = 1'b1;
        m1.data_out  = rdata_q;
        m1.error     = err_q;
      end
    end
  end

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Self-checking bench: a round-robin/timeout instance and a fixed-priority/no-timeout
// instance, driven by directed and random accesses against a transaction-level model.
module tb_mmu_port_arbiter;
  import mmu_port_arbiter_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        sgn;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] din;
  } treq_t;

  logic clk = 1'b0;
  logic reset;
  logic stickyA, stickyB;
  int   checks = 0;
  int   errors = 0;
  int   lastGrant;
  bit   modelSticky;

  mmu_port_arbiter_if m0a(), m1a(), mmua(), m0b(), m1b(), mmub();

  mmu_port_arbiter #(.RR_ENABLE(1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .m0(m0a), .m1(m1a), .mmu(mmua), .timeout_sticky(stickyA));

  mmu_port_arbiter #(.RR_ENABLE(0), .TIMEOUT_CYCLES(0)) dut_fp (
    .clk(clk), .reset(reset), .m0(m0b), .m1(m1b), .mmu(mmub), .timeout_sticky(stickyB));

  always #5 clk = ~clk;

  function automatic treq_t mk(input logic rd, input logic wr, input logic sgn,
                               input logic [1:0] w, input logic [31:0] addr, input logic [31:0] din);
    treq_t r;
    r.rd = rd; r.wr = wr; r.sgn = sgn; r.w = w; r.addr = addr; r.din = din;
    return r;
  endfunction

  // What the MMU should see for a request: a write wins over a simultaneous read.
  function automatic treq_t expView(input treq_t r);
    treq_t v = r;
    v.rd = r.rd & ~r.wr;
    return v;
  endfunction

  function automatic int modelPick(input bit r0, input bit r1, input int last, input bit rr);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    return rr ? (1 - last) : 0;
  endfunction

  // Masters 0/1 belong to the round-robin instance, 2/3 to the fixed-priority one.
  task automatic setReq(input int id, input treq_t r);
    case (id)
      0: begin m0a.read_enable = r.rd; m0a.write_enable = r.wr; m0a.mem_signed_read = r.sgn;
               m0a.mem_data_width = r.w; m0a.address = r.addr; m0a.data_in = r.din; end
      1: begin m1a.read_enable = r.rd; m1a.write_enable = r.wr; m1a.mem_signed_read = r.sgn;
               m1a.mem_data_width = r.w; m1a.address = r.addr; m1a.data_in = r.din; end
      2: begin m0b.read_enable = r.rd; m0b.write_enable = r.wr; m0b.mem_signed_read = r.sgn;
               m0b.mem_data_width = r.w; m0b.address = r.addr; m0b.data_in = r.din; end
      default: begin m1b.read_enable = r.rd; m1b.write_enable = r.wr; m1b.mem_signed_read = r.sgn;
               m1b.mem_data_width = r.w; m1b.address = r.addr; m1b.data_in = r.din; end
    endcase
  endtask

  task automatic goIdle();
    setReq(0, '0);
    setReq(1, '0);
    @(negedge clk);
  endtask

  // Plays the MMU for one access on the round-robin instance and reports what it saw.
  task automatic runAccess(input int lat, input logic [31:0] rdata, input bit pokeM1,
                           output bit expired, output int winner, output logic [31:0] dout,
                           output logic err, output int respCyc, output int issueCyc,
                           output treq_t seen, output bit held, output bit quiet);
    treq_t cur;
    bit done = 0;
    expired = 1; winner = -1; dout = '0; err = 1'b0; respCyc = 0; issueCyc = 0;
    seen = '0; held = 1; quiet = 1;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (m0a.mem_ready || m1a.mem_ready) begin
        done = 1; expired = 0; respCyc = c;
        winner = m1a.mem_ready ? 1 : 0;
        dout = winner ? m1a.data_out : m0a.data_out;
        err = winner ? m1a.error : m0a.error;
        quiet = !(m0a.mem_ready && m1a.mem_ready) && !mmua.read_enable && !mmua.write_enable &&
                (winner ? (m0a.data_out == 0 && !m0a.error) : (m1a.data_out == 0 && !m1a.error));
        mmua.mem_ready = 1'b0;
        mmua.data_out = '0;
      end else if (mmua.read_enable || mmua.write_enable) begin
        issueCyc++;
        cur = {mmua.read_enable, mmua.write_enable, mmua.mem_signed_read,
               mmua.mem_data_width, mmua.address, mmua.data_in};
        if (issueCyc == 1) seen = cur;
        else if (cur !== seen) held = 0;
        if (issueCyc == 1 && pokeM1) m1a.address = 32'hFFFF_FFF0;
        mmua.mem_ready = (issueCyc == lat);
        mmua.data_out = (issueCyc == lat) ? rdata : $urandom;
      end else begin
        mmua.mem_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setReq(0, '0); setReq(1, '0); setReq(2, '0); setReq(3, '0);
    mmua.mem_ready = 1'b0; mmua.data_out = '0; mmua.error = 1'b0;
    mmub.mem_ready = 1'b0; mmub.data_out = '0; mmub.error = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mmua.read_enable, mmua.write_enable, m0a.mem_ready, m1a.mem_ready, stickyA} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 00000",
               {mmua.read_enable, mmua.write_enable, m0a.mem_ready, m1a.mem_ready, stickyA});
    end
    checks++;
    if (mmua.address !== 32'h0 || m0a.data_out !== 32'h0 || m1a.data_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got addr=%h d0=%h d1=%h want 0", mmua.address, m0a.data_out, m1a.data_out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mmua.read_enable !== 1'b0 || mmub.read_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle got en=%b/%b want 0", mmua.read_enable, mmub.read_enable);
    end
    lastGrant = 1;
    modelSticky = 0;
  endtask

  task automatic test_single_read();
    bit expired, held, quiet; int win, respCyc, issueCyc; logic [31:0] dout; logic err; treq_t seen, r;
    goIdle();
    r = mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
    setReq(0, r);
    runAccess(2, 32'hDEADBEEF, 0, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
    lastGrant = 0;
    checks++;
    if (expired || win != 0 || respCyc != 3) begin
      errors++;
      $display("[TB] FAIL single_timing got exp=%0d win=%0d cyc=%0d want 0 0 3", expired, win, respCyc);
    end
    checks++;
    if (dout !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_data got %h err=%b want deadbeef err=0", dout, err);
    end
    checks++;
    if (seen !== expView(r) || !held || issueCyc != 2 || !quiet) begin
      errors++;
      $display("[TB] FAIL single_issue got %h held=%0d n=%0d quiet=%0d want %h 1 2 1",
               seen, held, issueCyc, quiet, expView(r));
    end
    goIdle();
    checks++;
    if (m0a.mem_ready !== 1'b0 || m0a.data_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL single_pulse got rdy=%b d=%h want 0 0", m0a.mem_ready, m0a.data_out);
    end
  endtask

  task automatic test_round_robin();
    bit expired, held, quiet; int win, respCyc, issueCyc, expWin; logic [31:0] dout; logic err;
    treq_t seen;
    treq_t r[2];
    goIdle();
    r[0] = mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0);
    r[1] = mk(1'b0, 1'b1, 1'b1, 2'b01, 32'h2000, 32'hCAFE_0001);
    setReq(0, r[0]);
    setReq(1, r[1]);
    for (int i = 0; i < 4; i++) begin
      expWin = modelPick(1, 1, lastGrant, 1);
      runAccess(1, 32'h5000 + i, 0, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
      checks++;
      if (expired || win != expWin || seen !== expView(r[expWin]) || dout !== 32'h5000 + i) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d got win=%0d addr=%h d=%h want win=%0d addr=%h d=%h",
                 i, win, seen.addr, dout, expWin, r[expWin].addr, 32'h5000 + i);
      end
      lastGrant = expWin;
    end
  endtask

  task automatic test_fixed_priority();
    int cnt0 = 0, cnt1 = 0, issue = 0, respCyc = 0;
    logic err = 1'b1;
    logic [31:0] dout = '0;
    bit done = 0;
    @(negedge clk);
    setReq(3, mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h40, 32'h0));
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      if (m1b.mem_ready) begin
        done = 1; respCyc = c; err = m1b.error; dout = m1b.data_out;
        mmub.mem_ready = 1'b0;
      end else if (mmub.read_enable || mmub.write_enable) begin
        issue++;
        mmub.mem_ready = (issue == 10);
        mmub.data_out = 32'hA5A5_0001;
      end
    end
    checks++;
    if (respCyc != 11 || err !== 1'b0 || dout !== 32'hA5A5_0001) begin
      errors++;
      $display("[TB] FAIL fp_no_timeout got cyc=%0d err=%b d=%h want 11 0 a5a50001", respCyc, err, dout);
    end
    setReq(2, mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h80, 32'h0));
    setReq(3, mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h90, 32'h0));
    for (int c = 0; c < 60 && cnt0 < 4; c++) begin
      @(negedge clk);
      if (m0b.mem_ready) cnt0++;
      if (m1b.mem_ready) cnt1++;
      mmub.mem_ready = mmub.read_enable | mmub.write_enable;
    end
    checks++;
    if (cnt0 != 4 || cnt1 != 0) begin
      errors++;
      $display("[TB] FAIL fp_starve got m0=%0d m1=%0d want 4 0", cnt0, cnt1);
    end
    setReq(2, '0);
    setReq(3, '0);
    mmub.mem_ready = 1'b0;
  endtask

  task automatic test_addr_hold();
    bit expired, held, quiet; int win, respCyc, issueCyc; logic [31:0] dout; logic err; treq_t seen, r;
    goIdle();
    r = mk(1'b0, 1'b1, 1'b0, 2'b00, 32'h204, 32'h55);
    setReq(1, r);
    runAccess(3, 32'h1234_5678, 1, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
    lastGrant = 1;
    checks++;
    if (expired || win != 1 || seen !== expView(r) || !held) begin
      errors++;
      $display("[TB] FAIL hold_addr got win=%0d seen=%h held=%0d want 1 %h 1", win, seen, held, expView(r));
    end
    checks++;
    if (dout !== 32'h1234_5678 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_data got %h err=%b want 12345678 0", dout, err);
    end
  endtask

  task automatic test_read_write_both();
    bit expired, held, quiet; int win, respCyc, issueCyc; logic [31:0] dout; logic err; treq_t seen, r;
    goIdle();
    r = mk(1'b1, 1'b1, 1'b0, 2'b10, 32'h300, 32'h7777_0000);
    setReq(0, r);
    runAccess(1, 32'h1, 0, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
    lastGrant = 0;
    checks++;
    if (expired || win != 0 || seen.rd !== 1'b0 || seen.wr !== 1'b1 || seen.din !== 32'h7777_0000) begin
      errors++;
      $display("[TB] FAIL rw_both got win=%0d rd=%b wr=%b din=%h want 0 0 1 77770000",
               win, seen.rd, seen.wr, seen.din);
    end
  endtask

  task automatic test_timeout();
    bit expired, held, quiet; int win, respCyc, issueCyc; logic [31:0] dout; logic err; treq_t seen;
    goIdle();
    setReq(0, mk(1'b1, 1'b0, 1'b1, 2'b01, 32'h500, 32'h0));
    runAccess(99, 32'h0, 0, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
    lastGrant = 0;
    modelSticky = 1;
    checks++;
    if (expired || win != 0 || respCyc != TMO + 1 || issueCyc != TMO) begin
      errors++;
      $display("[TB] FAIL tmo_timing got win=%0d cyc=%0d n=%0d want 0 %0d %0d", win, respCyc, issueCyc, TMO + 1, TMO);
    end
    checks++;
    if (err !== 1'b1 || dout !== 32'h0 || stickyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_error got err=%b d=%h sticky=%b want 1 0 1", err, dout, stickyA);
    end
    goIdle();
    setReq(0, mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h504, 32'h0));
    runAccess(TMO, 32'h0BAD_F00D, 0, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
    checks++;
    if (expired || respCyc != TMO + 1 || err !== 1'b0 || dout !== 32'h0BAD_F00D || stickyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_edge got cyc=%0d err=%b d=%h sticky=%b want %0d 0 0badf00d 1",
               respCyc, err, dout, stickyA, TMO + 1);
    end
  endtask

  task automatic test_random();
    bit expired, held, quiet, expTo; int win, respCyc, issueCyc, expWin, lat, sel;
    logic [31:0] dout, data, expData; logic err; treq_t seen;
    treq_t r[2];
    for (int i = 0; i < 24; i++) begin
      goIdle();
      sel = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        r[m] = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  2'($urandom_range(0, 2)), $urandom, $urandom);
        if (sel[m] && !r[m].rd && !r[m].wr) r[m].rd = 1'b1;
        if (!sel[m]) begin r[m].rd = 1'b0; r[m].wr = 1'b0; end
        setReq(m, r[m]);
      end
      lat = $urandom_range(1, 6);
      data = $urandom;
      expWin = modelPick(sel[0], sel[1], lastGrant, 1);
      expTo = lat > TMO;
      expData = expTo ? 32'h0 : data;
      modelSticky = modelSticky | expTo;
      runAccess(lat, data, 0, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
      checks++;
      if (expired || win != expWin || seen !== expView(r[expWin]) || !held || !quiet) begin
        errors++;
        $display("[TB] FAIL rand%0d_grant got win=%0d req=%h held=%0d quiet=%0d want %0d %h",
                 i, win, seen, held, quiet, expWin, expView(r[expWin]));
      end
      checks++;
      if (dout !== expData || err !== expTo || respCyc != (expTo ? TMO : lat) + 1 ||
          stickyA !== modelSticky) begin
        errors++;
        $display("[TB] FAIL rand%0d_resp got d=%h err=%b cyc=%0d sticky=%b want %h %b %0d %b",
                 i, dout, err, respCyc, stickyA, expData, expTo, (expTo ? TMO : lat) + 1, modelSticky);
      end
      lastGrant = expWin;
    end
  endtask

  task automatic test_reset_mid();
    bit expired, held, quiet, anyReady = 0; int win, respCyc, issueCyc; logic [31:0] dout; logic err;
    treq_t seen;
    goIdle();
    setReq(0, mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h700, 32'h0));
    @(negedge clk);
    checks++;
    if (mmua.read_enable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_issue got en=%b want 1", mmua.read_enable);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mmua.read_enable !== 1'b0 || mmua.write_enable !== 1'b0 || stickyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_async got rd=%b wr=%b sticky=%b want 0 0 0",
               mmua.read_enable, mmua.write_enable, stickyA);
    end
    setReq(0, '0);
    @(negedge clk);
    reset = 1'b0;
    lastGrant = 1;
    modelSticky = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m0a.mem_ready || m1a.mem_ready) anyReady = 1;
    end
    checks++;
    if (anyReady) begin
      errors++;
      $display("[TB] FAIL rstmid_noready got ready=1 want 0");
    end
    setReq(0, mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h800, 32'h0));
    setReq(1, mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h900, 32'h0));
    runAccess(1, 32'h3, 0, expired, win, dout, err, respCyc, issueCyc, seen, held, quiet);
    checks++;
    if (expired || win != modelPick(1, 1, lastGrant, 1) || seen.addr !== 32'h800) begin
      errors++;
      $display("[TB] FAIL rstmid_tie got win=%0d addr=%h want 0 00000800", win, seen.addr);
    end
    lastGrant = 0;
    goIdle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_addr_hold();
    test_read_write_both();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
